acc_muldiv: RTL and testbench

Accumulator stage of the 4-bit CPU datapath, wrapped around the ALU. It holds the 8-bit accumulator as high and low nibbles. It drives the ALU's A operand and the `alu_lsb`, `op_mul` and `op_div` controls, and writes `alu_data` / `cout` back. It sequences 4-step shift-add multiply and restoring divide, with the multiplicand or divisor in the external B register.

---
 rtl/acc_muldiv.sv | 160 ++++++++++++++++
 tb/tb_acc_muldiv.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_muldiv.sv
// Accumulator stage of the 4-bit CPU datapath: holds the 8-bit accumulator and
// sequences 4-step shift-add multiply and restoring divide through the external ALU.
module acc_muldiv (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       acc_clear,
   input  logic       acc_load_low,
   input  logic       acc_wr_alu,
   input  logic       start_mul,
   input  logic       start_div,
   input  logic [3:0] bus_data,
   input  logic [3:0] alu_data,
   input  logic       cout,
   output logic [3:0] acc_high_data,
   output logic [3:0] acc_low_data,
   output logic       alu_lsb,
   output logic       op_mul,
   output logic       op_div,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MUL       = 3'd1,
      ST_DIV_SHIFT = 3'd2,
      ST_DIV_SUB   = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_high;
   logic [3:0] r_low;
   logic       r_ext;
   logic [1:0] r_step;
   logic       r_busy;
   logic       r_done;
   logic       r_op_mul;
   logic       r_op_div;

   logic [3:0] w_high_nxt;
   logic [3:0] w_low_nxt;
   logic       w_ext_nxt;
   logic [1:0] w_step_nxt;
   logic [4:0] w_mul_sum;

   assign acc_high_data = r_high;
   assign acc_low_data  = r_low;
   assign alu_lsb       = r_low[0];
   assign op_mul        = r_op_mul;
   assign op_div        = r_op_div;
   assign busy          = r_busy;
   assign done          = r_done;

   // Next-state and next-datapath decode for the accumulator sequencer
   always_comb begin
      w_state_nxt = r_state;
      w_high_nxt  = r_high;
      w_low_nxt   = r_low;
      w_ext_nxt   = r_ext;
      w_step_nxt  = r_step;
      w_mul_sum   = 5'd0;
      case (r_state)
         ST_IDLE: begin
            if (acc_clear) begin
               w_high_nxt = 4'h0;
               w_low_nxt  = 4'h0;
            end else if (start_mul) begin
               w_high_nxt  = 4'h0;
               w_step_nxt  = 2'd0;
               w_state_nxt = ST_MUL;
            end else if (start_div) begin
               w_high_nxt  = 4'h0;
               w_ext_nxt   = 1'b0;
               w_step_nxt  = 2'd0;
               w_state_nxt = ST_DIV_SHIFT;
            end else begin
               if (acc_wr_alu) begin
                  w_high_nxt = alu_data;
               end else begin
                  w_high_nxt = r_high;
               end
               if (acc_load_low) begin
                  w_low_nxt = bus_data;
               end else begin
                  w_low_nxt = r_low;
               end
            end
         end
         ST_MUL: begin
            // Partial product carry lands in high[3] after the right shift
            if (r_low[0]) begin
               w_mul_sum = {cout, alu_data};
            end else begin
               w_mul_sum = {1'b0, r_high};
            end
            {w_high_nxt, w_low_nxt} = {w_mul_sum, r_low[3:1]};
            w_step_nxt = r_step + 2'd1;
            if (r_step == 2'd3) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_MUL;
            end
         end
         ST_DIV_SHIFT: begin
            {w_ext_nxt, w_high_nxt, w_low_nxt} = {r_high, r_low, 1'b0};
            w_state_nxt = ST_DIV_SUB;
         end
         ST_DIV_SUB: begin
            // ext set means the shifted remainder is >= 16, so the subtract always fits
            if (r_ext | cout) begin
               w_high_nxt = alu_data;
               w_low_nxt  = {r_low[3:1], 1'b1};
            end else begin
               w_high_nxt = r_high;
               w_low_nxt  = {r_low[3:1], 1'b0};
            end
            w_step_nxt = r_step + 2'd1;
            if (r_step == 2'd3) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_DIV_SHIFT;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_high   <= 4'h0;
         r_low    <= 4'h0;
         r_ext    <= 1'b0;
         r_step   <= 2'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_op_mul <= 1'b0;
         r_op_div <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_high   <= w_high_nxt;
         r_low    <= w_low_nxt;
         r_ext    <= w_ext_nxt;
         r_step   <= w_step_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
         r_done   <= (w_state_nxt == ST_DONE);
         r_op_mul <= (w_state_nxt == ST_MUL);
         r_op_div <= (w_state_nxt == ST_DIV_SUB);
      end
   end

endmodule

// File: tb/tb_acc_muldiv.sv
// Self-checking bench for acc_muldiv: behavioural ALU, arithmetic reference model,
// directed multiply/divide cases and randomized command mix.
module tb_acc_muldiv;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       acc_clear;
   logic       acc_load_low;
   logic       acc_wr_alu;
   logic       start_mul;
   logic       start_div;
   logic [3:0] bus_data;
   logic [3:0] alu_data;
   logic       cout;
   logic [3:0] acc_high_data;
   logic [3:0] acc_low_data;
   logic       alu_lsb;
   logic       op_mul;
   logic       op_div;
   logic       busy;
   logic       done;

   logic [3:0] b_reg;
   logic [4:0] w_add;
   logic [3:0] w_sub;

   int total = 0;
   int bad   = 0;
   int m_high;
   int m_low;

   acc_muldiv dut (
      .clk(clk), .reset_n(reset_n), .acc_clear(acc_clear), .acc_load_low(acc_load_low),
      .acc_wr_alu(acc_wr_alu), .start_mul(start_mul), .start_div(start_div),
      .bus_data(bus_data), .alu_data(alu_data), .cout(cout),
      .acc_high_data(acc_high_data), .acc_low_data(acc_low_data), .alu_lsb(alu_lsb),
      .op_mul(op_mul), .op_div(op_div), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // ALU: add normally, subtract with no-borrow carry while op_div is high
   assign w_add    = {1'b0, acc_high_data} + {1'b0, b_reg};
   assign w_sub    = acc_high_data - b_reg;
   assign alu_data = op_div ? w_sub : w_add[3:0];
   assign cout     = op_div ? (acc_high_data >= b_reg) : w_add[4];

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      acc_clear    = 1'b0;
      acc_load_low = 1'b0;
      acc_wr_alu   = 1'b0;
      start_mul    = 1'b0;
      start_div    = 1'b0;
   endtask

   task automatic chk_acc(input string tag);
      chk_eq({tag, "_hi"}, 32'(acc_high_data), 32'(m_high));
      chk_eq({tag, "_lo"}, 32'(acc_low_data), 32'(m_low));
      chk_eq({tag, "_lsb"}, 32'(alu_lsb), 32'(m_low & 1));
   endtask

   task automatic idle_cmd(input bit clr, input bit ld, input bit wr,
                           input logic [3:0] d, input logic [3:0] b);
      b_reg        = b;
      acc_clear    = clr;
      acc_load_low = ld;
      acc_wr_alu   = wr;
      bus_data     = d;
      tick();
      clr_inputs();
      if (clr) begin
         m_high = 0;
         m_low  = 0;
      end else begin
         if (wr) m_high = (m_high + int'(b)) % 16;
         if (ld) m_low = int'(d);
      end
      chk_acc("idle");
      chk_eq("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic run_op(input bit mul, input logic [3:0] a, input logic [3:0] b,
                         input bit meddle, input bit both);
      int lat;
      int prod;
      idle_cmd(1'b0, 1'b1, 1'b0, a, b);
      start_mul = mul;
      start_div = !mul || both;
      tick();
      clr_inputs();
      lat = mul ? 5 : 9;
      if (mul) begin
         prod   = int'(a) * int'(b);
         m_high = prod / 16;
         m_low  = prod % 16;
      end else if (b == 4'd0) begin
         m_high = int'(a);
         m_low  = 15;
      end else begin
         m_high = int'(a) % int'(b);
         m_low  = int'(a) / int'(b);
      end
      for (int cyc = 1; cyc <= lat; cyc++) begin
         chk_eq("busy", 32'(busy), 32'd1);
         chk_eq("done", 32'(done), 32'(cyc == lat));
         chk_eq("op_mul", 32'(op_mul), 32'(mul && cyc < lat));
         chk_eq("op_div", 32'(op_div), 32'(!mul && cyc < lat && (cyc % 2) == 0));
         if (cyc == lat) chk_acc(mul ? "mul_res" : "div_res");
         if (meddle && cyc == 2) begin
            acc_clear    = 1'b1;
            start_div    = 1'b1;
            start_mul    = 1'b1;
            acc_load_low = 1'b1;
            acc_wr_alu   = 1'b1;
            bus_data     = ~a;
         end
         tick();
         clr_inputs();
      end
      chk_eq("post_busy", 32'(busy), 32'd0);
      chk_eq("post_done", 32'(done), 32'd0);
      chk_acc("post_hold");
   endtask

   task automatic chk_reset_state(input string tag);
      chk_eq({tag, "_hi"}, 32'(acc_high_data), 32'd0);
      chk_eq({tag, "_lo"}, 32'(acc_low_data), 32'd0);
      chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
      chk_eq({tag, "_done"}, 32'(done), 32'd0);
      chk_eq({tag, "_opm"}, 32'(op_mul), 32'd0);
      chk_eq({tag, "_opd"}, 32'(op_div), 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      m_high = 0;
      m_low  = 0;
   endtask

   initial begin
      int done_seen;
      reset_n  = 1'b0;
      bus_data = 4'h0;
      b_reg    = 4'h0;
      clr_inputs();
      #12;
      chk_reset_state("rst");
      release_reset();

      // mid-cycle asynchronous reset with a nonzero accumulator
      idle_cmd(1'b0, 1'b1, 1'b1, 4'h6, 4'h9);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_state("async_rst");
      release_reset();

      run_op(1'b1, 4'hB, 4'hD, 1'b0, 1'b0);
      run_op(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
      run_op(1'b0, 4'hE, 4'h3, 1'b0, 1'b0);
      run_op(1'b0, 4'hF, 4'h2, 1'b0, 1'b0);
      run_op(1'b0, 4'h9, 4'h0, 1'b0, 1'b0);
      run_op(1'b1, 4'h7, 4'h5, 1'b1, 1'b0);
      run_op(1'b1, 4'h3, 4'hA, 1'b0, 1'b1);

      // clear takes priority over every other idle command
      acc_clear = 1'b1;
      start_mul = 1'b1;
      start_div = 1'b1;
      acc_load_low = 1'b1;
      bus_data = 4'h5;
      tick();
      clr_inputs();
      m_high = 0;
      m_low  = 0;
      chk_acc("clr_prio");
      chk_eq("clr_prio_busy", 32'(busy), 32'd0);

      // abort a divide in its third cycle
      idle_cmd(1'b0, 1'b1, 1'b0, 4'hE, 4'h3);
      start_div = 1'b1;
      tick();
      clr_inputs();
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_state("abort");
      release_reset();
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) done_seen++;
         tick();
      end
      chk_eq("abort_no_done", 32'(done_seen), 32'd0);
      chk_acc("abort_acc");

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: idle_cmd(1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                        4'($urandom), 4'($urandom));
            1: run_op(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
            2: run_op(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
            default: run_op(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
